// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into WIDTH-cycle output levels separated by GAP low cycles.
// Events arriving mid-pulse are queued in a saturating counter; dropped events set a sticky flag.
module pulse_stretcher #(
    parameter int WIDTH    = 4,
    parameter int GAP      = 2,
    parameter int PEND_MAX = 3,
    parameter int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    input  logic          clr_ovf,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          ovf
);

    localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] W_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP - 1);
    localparam logic [PW-1:0] PMAX   = PW'(PEND_MAX);

    generate
        if (WIDTH < 1 || GAP < 1 || PEND_MAX < 1) begin : g_bad_param
            $error("pulse_stretcher: WIDTH, GAP and PEND_MAX must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          enq;

    // An event is queued unless it starts a pulse (IDLE) or lands on the GAP exit edge.
    assign enq = in && ((state == S_HIGH) || (state == S_GAP && cnt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            if (clr_ovf)
                ovf <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (in) begin
                        state <= S_HIGH;
                        cnt   <= W_LOAD;
                    end
                end
                S_HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= S_GAP;
                        cnt   <= G_LOAD;
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (pending != '0) begin
                        // Dequeue; a simultaneous event refills the freed slot, so it never drops.
                        state <= S_HIGH;
                        cnt   <= W_LOAD;
                        if (!in)
                            pending <= pending - PW'(1);
                    end else if (in) begin
                        state <= S_HIGH;
                        cnt   <= W_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase

            // Placed after the clear so a drop on the same edge wins.
            if (enq) begin
                if (pending != PMAX)
                    pending <= pending + PW'(1);
                else
                    ovf <= 1'b1;
            end
        end
    end

    assign out  = (state == S_HIGH);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default parameters plus a minimum-parameter instance.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst, ev, clr, ev2, clr2;
    logic       out, busy, ovf;
    logic [1:0] pending;
    logic       out2, busy2, ovf2;
    logic [0:0] pending2;

    int checks = 0;
    int errors = 0;

    int s4p[14] = '{0, 1, 2, 3, 3, 3, 2, 2, 2, 2, 2, 3, 3, 3};
    int s4v[14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(4), .GAP(2), .PEND_MAX(3)) dut (
        .clk(clk), .rst(rst), .in(ev), .clr_ovf(clr),
        .out(out), .busy(busy), .pending(pending), .ovf(ovf)
    );

    pulse_stretcher #(.WIDTH(1), .GAP(1), .PEND_MAX(1)) dut_min (
        .clk(clk), .rst(rst), .in(ev2), .clr_ovf(clr2),
        .out(out2), .busy(busy2), .pending(pending2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input int k, input logic o, input logic b, input int p);
        chk({tag, "_out"}, k, {7'd0, out}, {7'd0, o});
        chk({tag, "_busy"}, k, {7'd0, busy}, {7'd0, b});
        chk({tag, "_pend"}, k, {6'd0, pending}, 8'(p));
    endtask

    initial begin
        rst = 1'b1; ev = 1'b0; clr = 1'b0; ev2 = 1'b0; clr2 = 1'b0;
        tick();
        tick();
        st("reset", 0, 1'b0, 1'b0, 0);
        chk("reset_ovf", 0, {7'd0, ovf}, 8'd0);
        chk("reset_min_out", 0, {7'd0, out2}, 8'd0);
        chk("reset_min_pend", 0, {7'd0, pending2}, 8'd0);
        rst = 1'b0;
        tick();
        st("idle", 0, 1'b0, 1'b0, 0);

        // Single event: high after edges 0..3, gap 4..5, idle from 6
        for (int k = 0; k < 8; k++) begin
            ev = (k == 0);
            tick();
            st("single", k, k <= 3, k <= 5, 0);
        end

        // Two adjacent events: second burst after edges 6..9, idle after 12
        for (int k = 0; k < 13; k++) begin
            ev = (k <= 1);
            tick();
            st("adjacent", k, (k <= 3) || (k >= 6 && k <= 9), k <= 11,
               (k >= 1 && k <= 5) ? 1 : 0);
        end

        // Event on the GAP exit edge is consumed directly
        for (int k = 0; k < 13; k++) begin
            ev = (k == 0) || (k == 6);
            tick();
            st("lastgap", k, (k <= 3) || (k >= 6 && k <= 9), k <= 11, 0);
        end

        // Overflow, sticky clear, refill on dequeue edge, clear colliding with drop
        for (int k = 0; k < 14; k++) begin
            ev  = (k <= 4) || (k >= 11);
            clr = (k == 10) || (k == 12) || (k == 13);
            tick();
            st("ovf", k, (k <= 3) || (k >= 6 && k <= 9) || k >= 12, 1'b1, s4p[k]);
            chk("ovf_flag", k, {7'd0, ovf}, 8'(s4v[k]));
        end

        // Reset overrides an event on the same edge and clears ovf and the queue
        ev = 1'b1; clr = 1'b0; rst = 1'b1;
        tick();
        st("rst_ovr", 0, 1'b0, 1'b0, 0);
        chk("rst_ovr_ovf", 0, {7'd0, ovf}, 8'd0);
        rst = 1'b0; ev = 1'b0;

        // Reset mid-pulse with two queued events, then a fresh event
        for (int k = 0; k < 10; k++) begin
            ev  = (k <= 3) || (k == 5);
            rst = (k == 3);
            tick();
            st("midrst", k, (k <= 2) || (k >= 5 && k <= 8), (k <= 2) || (k >= 5),
               (k <= 2) ? k : 0);
        end
        rst = 1'b0; ev = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Minimum parameters: held input alternates the output, queue never exceeds one
        for (int k = 0; k < 9; k++) begin
            ev2 = (k <= 5);
            tick();
            chk("min_out", k, {7'd0, out2}, {7'd0, (k <= 6) && (k % 2 == 0)});
            chk("min_busy", k, {7'd0, busy2}, {7'd0, k <= 7});
            chk("min_pend", k, {7'd0, pending2}, {7'd0, (k >= 1 && k <= 5)});
        end
        ev2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
